// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and the rotating-priority pick function
// for the 32-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit scanning ptr, ptr+1, ... with 5-bit wraparound.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter_32_decoder.sv
// 5-to-32 one-hot decoder with enable; purely combinational, no backpressure.
// All outputs are zero while en is low.
module decoder5_32 (
  input  logic        en,
  input  logic [4:0]  a,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    if (en) y = 32'd1 << a;
  end

endmodule

// File: rtl/rr_arbiter_32.sv
// Round-robin 32-way arbiter: grant appears one edge after a request in IDLE,
// held until done / request withdrawn / hold limit, then one dead IDLE cycle.
module rr_arbiter_32
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] gnt_id_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             timeout_nxt;
  logic             early_rel;
  logic             hold_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_id   <= gnt_id_nxt;
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_id_nxt  = gnt_id;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    early_rel   = done || !req[gnt_id];
    hold_exp    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_id_nxt = rr_pick(req, ptr);
          hold_nxt   = '0;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (early_rel || hold_exp) begin
          state_nxt   = IDLE;
          ptr_nxt     = gnt_id + IDX_W'(1);
          // Explicit release wins over the hold limit on the same edge.
          timeout_nxt = !early_rel;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_valid = (state == GRANT);

  decoder5_32 u_dec (
    .en (gnt_valid),
    .a  (gnt_id),
    .y  (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Directed bench for rr_arbiter_32: vector table plus hand-written
// sequences for rotation, hold timeout and done/timeout precedence.
module tb_rr_arbiter_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic        done;
  logic [31:0] gnt;
  logic [4:0]  gnt_id;
  logic        gnt_valid;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] req;
    logic        done;
    logic        exp_valid;
    logic [4:0]  exp_id;
    logic        exp_to;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter_32 #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Drive inputs, let one rising edge sample them, then settle before checking.
  task automatic step(input logic r, input logic [31:0] q, input logic d);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [4:0] eid,
                       input logic eto);
    logic [31:0] eg;
    eg = ev ? (32'd1 << eid) : 32'd0;
    checks++;
    if (gnt_valid !== ev) begin
      failures++;
      $display("FAIL %s gnt_valid: got %b want %b", name, gnt_valid, ev);
    end
    checks++;
    if (gnt_id !== eid) begin
      failures++;
      $display("FAIL %s gnt_id: got %0d want %0d", name, gnt_id, eid);
    end
    checks++;
    if (gnt !== eg) begin
      failures++;
      $display("FAIL %s gnt: got %h want %h", name, gnt, eg);
    end
    checks++;
    if (timeout !== eto) begin
      failures++;
      $display("FAIL %s timeout: got %b want %b", name, timeout, eto);
    end
  endtask

  task automatic add(input string n, input logic r, input logic [31:0] q,
                     input logic d, input logic ev, input logic [4:0] eid,
                     input logic eto);
    vec_t v;
    v.name = n; v.rst = r; v.req = q; v.done = d;
    v.exp_valid = ev; v.exp_id = eid; v.exp_to = eto;
    vecs.push_back(v);
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    //   name          rst  req            done valid id  to
    add("reset0",      1, 32'hFFFF_FFFF, 0,   0,    0,  0);
    add("reset1",      1, 32'hFFFF_FFFF, 0,   0,    0,  0);
    add("reset2",      1, 32'hFFFF_FFFF, 0,   0,    0,  0);
    add("grant20",     0, 32'h0010_0000, 0,   1,   20,  0);
    add("done20",      0, 32'h0010_0000, 1,   0,   20,  0);
    add("idle_done",   0, 32'h0000_0000, 1,   0,   20,  0);
    add("scan_at21",   0, 32'h0020_0001, 0,   1,   21,  0);
    add("other_req",   0, 32'h0020_0003, 0,   1,   21,  0);
    add("done21",      0, 32'h0020_0001, 1,   0,   21,  0);
    add("wrap_to8",    0, 32'h0000_0100, 0,   1,    8,  0);
    add("withdraw8",   0, 32'h0000_0001, 0,   0,    8,  0);
    add("wrap_to0",    0, 32'h0000_0001, 0,   1,    0,  0);
    add("done0",       0, 32'h0000_0001, 1,   0,    0,  0);
    add("grant7",      0, 32'h0000_0080, 0,   1,    7,  0);
    add("hold7",       0, 32'h0000_00FF, 0,   1,    7,  0);
    add("rst_mid7",    1, 32'h0000_0081, 0,   0,    0,  0);
    add("post_rst0",   0, 32'h0000_0081, 0,   1,    0,  0);
    add("done_post",   0, 32'h0000_0081, 1,   0,    0,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      check(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_id, vecs[i].exp_to);
    end

    // Full rotation 0..31 then wrap to 0, done on the second grant cycle.
    step(1'b1, 32'h0, 1'b0);
    for (int g = 0; g < 33; g++) begin
      step(1'b0, 32'hFFFF_FFFF, 1'b0);
      check("rot_grant", 1'b1, 5'(g % 32), 1'b0);
      step(1'b0, 32'hFFFF_FFFF, 1'b0);
      check("rot_hold", 1'b1, 5'(g % 32), 1'b0);
      step(1'b0, 32'hFFFF_FFFF, 1'b1);
      check("rot_idle", 1'b0, 5'(g % 32), 1'b0);
    end

    // Hold limit: requester 3 held exactly 16 cycles, timeout, dead cycle, regrant.
    step(1'b1, 32'h0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 32'h0000_0008, 1'b0);
      check("hold3", 1'b1, 5'd3, 1'b0);
    end
    step(1'b0, 32'h0000_0008, 1'b0);
    check("timeout3", 1'b0, 5'd3, 1'b1);
    step(1'b0, 32'h0000_0008, 1'b0);
    check("regrant3", 1'b1, 5'd3, 1'b0);

    // done coincident with the last hold cycle suppresses timeout.
    step(1'b1, 32'h0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 32'h0000_0008, 1'b0);
    end
    check("pre_limit", 1'b1, 5'd3, 1'b0);
    step(1'b0, 32'h0000_0008, 1'b1);
    check("done_at_limit", 1'b0, 5'd3, 1'b0);
    step(1'b0, 32'h0000_0000, 1'b0);
    check("idle_after", 1'b0, 5'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
